// File: rtl/farbborg_pkg.sv
// farbborg_pkg: scan FSM states, latch geometry and packed brightness field helper
package farbborg_pkg;
    typedef enum logic [3:0] {IDLE, CLR, ADR, WAIT, DATA, LCLK, BLANK, PCLK, SHOW} scan_state_t;
    localparam int LED_PER_LATCH = 8;
    localparam int MAX_BW = 16;
    localparam int DAT_MAX = LED_PER_LATCH * MAX_BW;
    function automatic logic [MAX_BW-1:0] led_bright(input logic [DAT_MAX-1:0] dat, input int bw, input int i);
        logic [DAT_MAX-1:0] mask;
        mask = (DAT_MAX'(1) << bw) - DAT_MAX'(1);
        return MAX_BW'((dat >> (i * bw)) & mask);
    endfunction
endpackage

// File: rtl/farbborg_pwm_cmp.sv
// farbborg_pwm_cmp: lights each of the 8 LEDs whose brightness exceeds the sub-frame counter
module farbborg_pwm_cmp
    import farbborg_pkg::*;
#(
    parameter int BRIGHT_W = 6
) (
    input  logic [LED_PER_LATCH*BRIGHT_W-1:0] dat,
    input  logic [BRIGHT_W-1:0]               pwm,
    output logic [LED_PER_LATCH-1:0]          pattern
);
    logic [DAT_MAX-1:0] ext;
    assign ext = DAT_MAX'(dat);
    for (genvar i = 0; i < LED_PER_LATCH; i++) begin : g_led
        assign pattern[i] = led_bright(ext, BRIGHT_W, i) > MAX_BW'(pwm);
    end
endmodule

// File: rtl/farbborg_scan.sv
// farbborg_scan: LED cube scan engine; reads the frame buffer, PWM-compares and drives
// the latch/plane shift registers and column enable, one sub-frame at a time.
module farbborg_scan
    import farbborg_pkg::*;
#(
    parameter int NUM_PLANES  = 8,
    parameter int NUM_LATCHES = 24,
    parameter int BRIGHT_W    = 6,
    parameter int SHOW_CYCLES = 256,
    parameter int ADR_W       = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    output logic [ADR_W-1:0]                  buf_adr,
    input  logic [LED_PER_LATCH*BRIGHT_W-1:0] buf_dat,
    output logic                              lsr_clr,
    output logic                              lsr_d,
    output logic                              lsr_c,
    output logic [LED_PER_LATCH-1:0]          latch_data,
    output logic                              psr_c,
    output logic                              psr_d,
    output logic                              col_enable,
    output logic                              frame_sync
);
    localparam int PL_W = NUM_PLANES > 1 ? $clog2(NUM_PLANES) : 1;
    localparam int LA_W = NUM_LATCHES > 1 ? $clog2(NUM_LATCHES) : 1;
    localparam int SH_W = SHOW_CYCLES > 1 ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [BRIGHT_W-1:0] PWM_LAST = BRIGHT_W'(2**BRIGHT_W - 2);
    localparam logic [PL_W-1:0] PLANE_LAST = PL_W'(NUM_PLANES - 1);
    localparam logic [LA_W-1:0] LATCH_LAST = LA_W'(NUM_LATCHES - 1);
    localparam logic [SH_W-1:0] SHOW_LAST = SH_W'(SHOW_CYCLES - 1);

    scan_state_t state, state_nxt;
    logic [PL_W-1:0] plane;
    logic [LA_W-1:0] latch;
    logic [BRIGHT_W-1:0] pwm;
    logic [SH_W-1:0] show_cnt;
    logic [LED_PER_LATCH-1:0] pattern;
    logic latch_last, show_last, pwm_last;

    farbborg_pwm_cmp #(.BRIGHT_W(BRIGHT_W)) u_cmp (
        .dat    (buf_dat),
        .pwm    (pwm),
        .pattern(pattern)
    );

    assign latch_last = latch == LATCH_LAST;
    assign show_last  = show_cnt == SHOW_LAST;
    assign pwm_last   = pwm == PWM_LAST;

    // IDLE only advances while enabled; the register stage forces IDLE otherwise
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = CLR;
            CLR:     state_nxt = ADR;
            ADR:     state_nxt = WAIT;
            WAIT:    state_nxt = DATA;
            DATA:    state_nxt = LCLK;
            LCLK:    state_nxt = latch_last ? BLANK : ADR;
            BLANK:   state_nxt = pwm == '0 ? PCLK : SHOW;
            PCLK:    state_nxt = SHOW;
            SHOW:    state_nxt = show_last ? CLR : SHOW;
            default: state_nxt = IDLE;
        endcase
    end

    assign lsr_clr    = state == CLR;
    assign lsr_c      = state == LCLK;
    assign psr_c      = state == PCLK;
    assign col_enable = state == SHOW;
    assign frame_sync = col_enable && show_last && pwm_last && plane == PLANE_LAST;
    // psr_d settles during BLANK so it is stable ahead of the psr_c rising edge
    assign psr_d      = ((state == BLANK && pwm == '0) || state == PCLK) && plane == '0;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state      <= IDLE;
            plane      <= '0;
            latch      <= '0;
            pwm        <= '0;
            show_cnt   <= '0;
            buf_adr    <= '0;
            latch_data <= '0;
            lsr_d      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                CLR: begin
                    latch    <= '0;
                    show_cnt <= '0;
                end
                ADR:  buf_adr <= ADR_W'(plane) * ADR_W'(NUM_LATCHES) + ADR_W'(latch);
                DATA: begin
                    latch_data <= pattern;
                    lsr_d      <= latch == '0;
                end
                LCLK: if (!latch_last) latch <= latch + 1'b1;
                SHOW: begin
                    show_cnt <= show_cnt + 1'b1;
                    if (show_last) begin
                        pwm <= pwm_last ? '0 : pwm + 1'b1;
                        if (pwm_last) plane <= plane == PLANE_LAST ? '0 : plane + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_farbborg_scan.sv
// tb_farbborg_scan: scoreboard bench for farbborg_scan on a small 2-plane, 2-latch cube
module tb_farbborg_scan;
    localparam int NP = 2, NL = 2, BW = 2, SC = 4, AW = 8;
    localparam int NSUB = (1 << BW) - 1;
    localparam int FRAME = NP * NSUB;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [AW-1:0] buf_adr;
    logic [8*BW-1:0] buf_dat = '0;
    logic lsr_clr, lsr_d, lsr_c, psr_c, psr_d, col_enable, frame_sync;
    logic [7:0] latch_data;
    logic [22:0] outs;
    logic [8*BW-1:0] mem [0:255];
    logic [7:0] seen [0:NL-1];
    int lit [0:NP*NL*8-1];
    int checks = 0, failures = 0;

    farbborg_scan #(
        .NUM_PLANES (NP),
        .NUM_LATCHES(NL),
        .BRIGHT_W   (BW),
        .SHOW_CYCLES(SC),
        .ADR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .buf_adr   (buf_adr),
        .buf_dat   (buf_dat),
        .lsr_clr   (lsr_clr),
        .lsr_d     (lsr_d),
        .lsr_c     (lsr_c),
        .latch_data(latch_data),
        .psr_c     (psr_c),
        .psr_d     (psr_d),
        .col_enable(col_enable),
        .frame_sync(frame_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) buf_dat <= mem[buf_adr];
    assign outs = {buf_adr, latch_data, lsr_clr, lsr_d, lsr_c, psr_c, psr_d, col_enable, frame_sync};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bright(input int a, input int i);
        return int'(mem[a] >> (i * BW)) & ((1 << BW) - 1);
    endfunction

    function automatic logic [7:0] expect_pat(input int a, input int pw);
        for (int i = 0; i < 8; i++) expect_pat[i] = bright(a, i) > pw;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
    endtask

    // Walks n sub-frames from a fresh start (plane 0, pwm 0), checking each against the scan rules
    task automatic run_subframes(input int n, output int first_wait);
        int len, lc, pc, ce, fs, ovl, pl, pw;
        first_wait = 0;
        foreach (lit[q]) lit[q] = 0;
        do begin
            step();
            first_wait++;
        end while (!lsr_clr && first_wait < 200);
        check("first_clr", 32'(lsr_clr), 1);
        for (int k = 0; k < n; k++) begin
            pl = (k / NSUB) % NP;
            pw = k % NSUB;
            len = 0; lc = 0; pc = 0; ce = 0; fs = 0; ovl = 0;
            do begin
                step();
                len++;
                if (col_enable && (lsr_c || psr_c || lsr_clr)) ovl++;
                if (lsr_c) begin
                    if (lc < NL) begin
                        check("lsr_adr", 32'(buf_adr), pl * NL + lc);
                        check("latch_data", 32'(latch_data), 32'(expect_pat(pl * NL + lc, pw)));
                        check("lsr_d", 32'(lsr_d), lc == 0 ? 1 : 0);
                        seen[lc] = latch_data;
                    end
                    lc++;
                end
                if (psr_c) begin
                    check("psr_d", 32'(psr_d), pl == 0 ? 1 : 0);
                    pc++;
                end
                if (col_enable) begin
                    ce++;
                    if (ce == 1)
                        for (int j = 0; j < NL; j++)
                            for (int i = 0; i < 8; i++)
                                if (seen[j][i]) lit[(pl * NL + j) * 8 + i]++;
                end
                if (frame_sync) begin
                    fs++;
                    check("fs_pos", ce, SC);
                end
            end while (!lsr_clr && len < 200);
            check("sub_len", len, 4 * NL + 2 + SC + (pw == 0 ? 1 : 0));
            check("lclk_cnt", lc, NL);
            check("pclk_cnt", pc, pw == 0 ? 1 : 0);
            check("show_len", ce, SC);
            check("fs_cnt", fs, (k % FRAME) == FRAME - 1 ? 1 : 0);
            check("overlap", ovl, 0);
        end
        if (n % FRAME == 0)
            for (int a = 0; a < NP * NL; a++)
                for (int i = 0; i < 8; i++)
                    check("lit_cnt", lit[a * 8 + i], bright(a, i) * (n / FRAME));
    endtask

    initial begin
        int w, any;
        foreach (mem[a]) mem[a] = '0;
        repeat (3) step();
        check("rst_outs", 32'(outs), 0);
        reset = 1'b0;
        any = 0;
        repeat (20) begin
            step();
            if (outs != '0) any = 1;
        end
        check("idle_outs", any, 0);
        check("idle_adr", 32'(buf_adr), 0);
        for (int a = 0; a < NP * NL; a++) mem[a] = 16'hFFFF;
        restart();
        run_subframes(FRAME, w);
        for (int a = 0; a < NP * NL; a++) mem[a] = '0;
        mem[0] = 16'h0009;
        restart();
        run_subframes(FRAME, w);
        check("restart_wait", w, 1);
        restart();
        w = 0;
        do begin
            step();
            w++;
        end while (!col_enable && w < 200);
        check("show_seen", 32'(col_enable), 1);
        enable = 1'b0;
        step();
        check("drop_col", 32'(col_enable), 0);
        check("drop_outs", 32'(outs), 0);
        enable = 1'b1;
        run_subframes(1, w);
        check("reen_wait", w, 1);
        repeat (3) begin
            for (int a = 0; a < NP * NL; a++) mem[a] = 16'($urandom);
            restart();
            run_subframes(FRAME, w);
        end
        restart();
        repeat ($urandom_range(5, 60)) step();
        reset = 1'b1;
        step();
        check("midrst_outs", 32'(outs), 0);
        reset = 1'b0;
        run_subframes(NSUB, w);
        check("midrst_wait", w, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
